// File: rtl/mux4_rr_collector_if.sv
// Bundle of the four source channels and the shared output channel of mux4_rr_collector.
interface mux4_rr_collector_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] a_dat, b_dat, c_dat, d_dat;
  logic             a_vld, b_vld, c_vld, d_vld;
  logic             a_rdy, b_rdy, c_rdy, d_rdy;
  logic [WIDTH-1:0] out_dat;
  logic [1:0]       out_sel;
  logic             out_vld;
  logic             out_rdy;

  modport slave (
    input  a_dat, b_dat, c_dat, d_dat,
    input  a_vld, b_vld, c_vld, d_vld,
    output a_rdy, b_rdy, c_rdy, d_rdy,
    output out_dat, out_sel, out_vld,
    input  out_rdy
  );

  modport master (
    output a_dat, b_dat, c_dat, d_dat,
    output a_vld, b_vld, c_vld, d_vld,
    input  a_rdy, b_rdy, c_rdy, d_rdy,
    input  out_dat, out_sel, out_vld,
    output out_rdy
  );
endinterface

// File: rtl/mux4_rr_collector.sv
// 4-to-1 round-robin collector with single-entry registered output and source tag.
// Define MUX4_FIXED_PRIO_EN for fixed priority a>b>c>d instead of round-robin.
module mux4_rr_collector #(
  parameter int unsigned WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  mux4_rr_collector_if.slave   bus
);

  logic [3:0]       vld;
  logic [WIDTH-1:0] dat [4];
  logic [3:0]       rdy;
  logic             slot_free;
  logic             gnt_vld;
  logic [1:0]       gnt_idx;

  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_dat_q, out_dat_d;
  logic [1:0]       out_sel_q, out_sel_d;
`ifndef MUX4_FIXED_PRIO_EN
  logic [1:0]       last_q, last_d;
  logic [1:0]       rr_idx;
`endif

  assign vld    = {bus.d_vld, bus.c_vld, bus.b_vld, bus.a_vld};
  assign dat[0] = bus.a_dat;
  assign dat[1] = bus.b_dat;
  assign dat[2] = bus.c_dat;
  assign dat[3] = bus.d_dat;

  // Slot can accept when empty or when the held word leaves this same edge.
  assign slot_free = !out_vld_q || bus.out_rdy;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rdy     = '0;
`ifndef MUX4_FIXED_PRIO_EN
    rr_idx  = '0;
`endif
    if (slot_free) begin
`ifdef MUX4_FIXED_PRIO_EN
      for (int unsigned i = 0; i < 4; i++) begin
        if (!gnt_vld && vld[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = 2'(i);
        end
      end
`else
      // Search starts one past the last grant; 2-bit add wraps 3 -> 0.
      for (int unsigned k = 1; k <= 4; k++) begin
        rr_idx = last_q + 2'(k);
        if (!gnt_vld && vld[rr_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = rr_idx;
        end
      end
`endif
      if (gnt_vld) rdy[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    out_sel_d = out_sel_q;
`ifndef MUX4_FIXED_PRIO_EN
    last_d    = last_q;
`endif
    if (gnt_vld) begin
      out_vld_d = 1'b1;
      out_dat_d = dat[gnt_idx];
      out_sel_d = gnt_idx;
`ifndef MUX4_FIXED_PRIO_EN
      last_d    = gnt_idx;
`endif
    end else if (out_vld_q && bus.out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_sel_q <= '0;
`ifndef MUX4_FIXED_PRIO_EN
      last_q    <= '1;
`endif
    end else begin
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      out_sel_q <= out_sel_d;
`ifndef MUX4_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  assign bus.a_rdy   = rdy[0];
  assign bus.b_rdy   = rdy[1];
  assign bus.c_rdy   = rdy[2];
  assign bus.d_rdy   = rdy[3];
  assign bus.out_vld = out_vld_q;
  assign bus.out_dat = out_dat_q;
  assign bus.out_sel = out_sel_q;

endmodule

// File: tb/tb_mux4_rr_collector.sv
// Directed self-checking bench for mux4_rr_collector (round-robin or MUX4_FIXED_PRIO_EN build).
module tb_mux4_rr_collector;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  mux4_rr_collector_if #(.WIDTH(8)) bus ();

  mux4_rr_collector #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past 200000 time units, expected finish earlier");
    $fatal(1);
  end

  task automatic drive(input logic [3:0] v, input logic [7:0] da, input logic [7:0] db,
                       input logic [7:0] dc, input logic [7:0] dd, input logic ordy);
    bus.a_vld = v[0]; bus.b_vld = v[1]; bus.c_vld = v[2]; bus.d_vld = v[3];
    bus.a_dat = da;   bus.b_dat = db;   bus.c_dat = dc;   bus.d_dat = dd;
    bus.out_rdy = ordy;
  endtask

  task automatic quick_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      #1;
      n_checks++;
      if ({bus.out_vld, bus.out_sel, bus.out_dat} !== 11'h000) begin
        n_fails++;
        $display("FAIL reset_out[%0d]: got vld/sel/dat %h, expected 000", i, {bus.out_vld, bus.out_sel, bus.out_dat});
      end
      n_checks++;
      if ({bus.d_rdy, bus.c_rdy, bus.b_rdy, bus.a_rdy} !== 4'b0000) begin
        n_fails++;
        $display("FAIL reset_rdy[%0d]: got %b, expected 0000", i, {bus.d_rdy, bus.c_rdy, bus.b_rdy, bus.a_rdy});
      end
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    drive(4'b0100, 8'h00, 8'h00, 8'h5A, 8'h00, 1'b1);
    #1;
    n_checks++;
    if ({bus.d_rdy, bus.c_rdy, bus.b_rdy, bus.a_rdy} !== 4'b0100) begin
      n_fails++;
      $display("FAIL single_rdy: got %b, expected 0100", {bus.d_rdy, bus.c_rdy, bus.b_rdy, bus.a_rdy});
    end
    @(negedge clk);
    drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    n_checks++;
    if ({bus.out_vld, bus.out_sel, bus.out_dat} !== {1'b1, 2'd2, 8'h5A}) begin
      n_fails++;
      $display("FAIL single_out: got %h, expected %h", {bus.out_vld, bus.out_sel, bus.out_dat}, {1'b1, 2'd2, 8'h5A});
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_vld !== 1'b0) begin
      n_fails++;
      $display("FAIL single_drain: got out_vld %b, expected 0", bus.out_vld);
    end
  endtask

`ifndef MUX4_FIXED_PRIO_EN
  task automatic test_round_robin();
    logic [1:0] exp_sel;
    logic [7:0] exp_dat;
    quick_reset();
    @(negedge clk);
    drive(4'b1111, 8'h10, 8'h20, 8'h30, 8'h40, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_sel = 2'(i % 4);
      exp_dat = 8'(((i % 4) + 1) * 16);
      if (i == 7) drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      n_checks++;
      if ({bus.out_vld, bus.out_sel, bus.out_dat} !== {1'b1, exp_sel, exp_dat}) begin
        n_fails++;
        $display("FAIL rr_seq[%0d]: got vld/sel/dat %h, expected %h", i, {bus.out_vld, bus.out_sel, bus.out_dat}, {1'b1, exp_sel, exp_dat});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    quick_reset();
    @(negedge clk);
    drive(4'b0010, 8'h00, 8'h20, 8'h00, 8'h00, 1'b0);
    #1;
    n_checks++;
    if ({bus.d_rdy, bus.c_rdy, bus.b_rdy, bus.a_rdy} !== 4'b0010) begin
      n_fails++;
      $display("FAIL bp_load_rdy: got %b, expected 0010", {bus.d_rdy, bus.c_rdy, bus.b_rdy, bus.a_rdy});
    end
    @(negedge clk);
    drive(4'b1001, 8'h11, 8'h00, 8'h00, 8'h44, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_checks++;
      if ({bus.out_vld, bus.out_sel, bus.out_dat} !== {1'b1, 2'd1, 8'h20}) begin
        n_fails++;
        $display("FAIL bp_hold[%0d]: got %h, expected %h", i, {bus.out_vld, bus.out_sel, bus.out_dat}, {1'b1, 2'd1, 8'h20});
      end
      n_checks++;
      if ({bus.d_rdy, bus.c_rdy, bus.b_rdy, bus.a_rdy} !== 4'b0000) begin
        n_fails++;
        $display("FAIL bp_rdy[%0d]: got %b, expected 0000", i, {bus.d_rdy, bus.c_rdy, bus.b_rdy, bus.a_rdy});
      end
    end
    bus.out_rdy = 1'b1;
    #1;
    n_checks++;
    if ({bus.d_rdy, bus.c_rdy, bus.b_rdy, bus.a_rdy} !== 4'b1000) begin
      n_fails++;
      $display("FAIL bp_release_rdy: got %b, expected 1000", {bus.d_rdy, bus.c_rdy, bus.b_rdy, bus.a_rdy});
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({bus.out_vld, bus.out_sel, bus.out_dat, bus.a_rdy} !== {1'b1, 2'd3, 8'h44, 1'b1}) begin
      n_fails++;
      $display("FAIL bp_grant_d: got vld/sel/dat/a_rdy %h, expected %h", {bus.out_vld, bus.out_sel, bus.out_dat, bus.a_rdy}, {1'b1, 2'd3, 8'h44, 1'b1});
    end
    @(negedge clk);
    drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    n_checks++;
    if ({bus.out_vld, bus.out_sel, bus.out_dat} !== {1'b1, 2'd0, 8'h11}) begin
      n_fails++;
      $display("FAIL bp_grant_a: got %h, expected %h", {bus.out_vld, bus.out_sel, bus.out_dat}, {1'b1, 2'd0, 8'h11});
    end
    @(negedge clk);
  endtask
`else
  task automatic test_fixed_prio();
    quick_reset();
    @(negedge clk);
    drive(4'b1111, 8'h10, 8'h20, 8'h30, 8'h40, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_checks++;
      if ({bus.d_rdy, bus.c_rdy, bus.b_rdy, bus.a_rdy} !== 4'b0001) begin
        n_fails++;
        $display("FAIL fp_rdy[%0d]: got %b, expected 0001", i, {bus.d_rdy, bus.c_rdy, bus.b_rdy, bus.a_rdy});
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      n_checks++;
      if ({bus.out_vld, bus.out_sel, bus.out_dat} !== {1'b1, 2'd0, 8'h10}) begin
        n_fails++;
        $display("FAIL fp_out[%0d]: got %h, expected %h", i, {bus.out_vld, bus.out_sel, bus.out_dat}, {1'b1, 2'd0, 8'h10});
      end
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_async_reset();
    @(negedge clk);
    drive(4'b0010, 8'h00, 8'h77, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    n_checks++;
    if ({bus.out_vld, bus.out_sel, bus.out_dat} !== {1'b1, 2'd1, 8'h77}) begin
      n_fails++;
      $display("FAIL ar_preload: got %h, expected %h", {bus.out_vld, bus.out_sel, bus.out_dat}, {1'b1, 2'd1, 8'h77});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_vld, bus.out_sel, bus.out_dat} !== 11'h000) begin
      n_fails++;
      $display("FAIL ar_clear: got %h before next edge, expected 000", {bus.out_vld, bus.out_sel, bus.out_dat});
    end
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    drive(4'b1111, 8'h10, 8'h20, 8'h30, 8'h40, 1'b1);
    #1;
    n_checks++;
    if ({bus.d_rdy, bus.c_rdy, bus.b_rdy, bus.a_rdy} !== 4'b0001) begin
      n_fails++;
      $display("FAIL ar_first_rdy: got %b, expected 0001", {bus.d_rdy, bus.c_rdy, bus.b_rdy, bus.a_rdy});
    end
    @(negedge clk);
    drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    n_checks++;
    if ({bus.out_vld, bus.out_sel, bus.out_dat} !== {1'b1, 2'd0, 8'h10}) begin
      n_fails++;
      $display("FAIL ar_first_out: got %h, expected %h", {bus.out_vld, bus.out_sel, bus.out_dat}, {1'b1, 2'd0, 8'h10});
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_single();
`ifndef MUX4_FIXED_PRIO_EN
    test_round_robin();
    test_backpressure();
`else
    test_fixed_prio();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
